result_readout: RTL

- Consumer/reader end of the systolic array result path: captures the 16 signed 8-bit results written by the loader/array and presents them one at a time on the 8-bit LED bus.
- Advances through the results on a debounced push-button press (the result_toggle button).
- Sits between the array result writer and the board LEDs and button; owns debouncing, index stepping and display gating.

---
 rtl/result_readout.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/result_readout.sv
// result_readout
//   Reader end of the systolic array result path. Captures the DEPTH signed
//   result words written by the array side and shows them one at a time on
//   the LED bus, stepping to the next word on each debounced button press.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-high reset
//   wr_en          result write strobe (accepted in any state)
//   wr_addr        result write index
//   wr_data        signed result word
//   process_done   level, high once all results are written
//   result_toggle  raw asynchronous push-button level
//   led            signed result currently displayed (0 while idle)
//   idx            index currently displayed
//   showing        high while the display state machine is in SHOW
//   wrap_pulse     one-cycle pulse when idx wraps from DEPTH-1 to 0
//
// Handshake: there is no valid/ready flow control here. wr_en is a plain
// write strobe sampled on every clk edge; process_done is a level that
// gates the display.
//
// Button to LED latency: 2 cycles synchroniser, DEBOUNCE_CYCLES debounce,
// 1 cycle press edge register, 1 cycle idx update, 1 cycle led register.
module result_readout #(
  parameter int DATA_W          = 8,
  parameter int DEPTH           = 16,
  parameter int ADDR_W          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     process_done,
  input  logic                     result_toggle,
  output logic signed [DATA_W-1:0] led,
  output logic [ADDR_W-1:0]        idx,
  output logic                     showing,
  output logic                     wrap_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // Result register file. Deliberately not reset so results survive a
  // reset of the display logic.
  logic signed [DATA_W-1:0] mem_q [DEPTH];

  logic             sync1_q;
  logic             sync2_q;
  logic             db_q;
  logic             db_prev_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic signed [DATA_W-1:0] led_q, led_d;
  logic                     wrap_q, wrap_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Two-flop synchroniser, debounce counter and press edge detector.
  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any agreement (a bounce back) restarts it from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      press_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= result_toggle;
      sync2_q   <= sync1_q;
      if (sync2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        db_q  <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      db_prev_q <= db_q;
      // Press only on a debounced rise; release produces nothing.
      press_q   <= db_q & ~db_prev_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      led_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      led_q   <= led_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    led_d   = '0;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Presses are ignored until the results are complete.
        if (process_done) begin
          state_d = SHOW;
          idx_d   = '0;
        end
      end
      SHOW: begin
        if (!process_done) begin
          // A new computation is starting; this wins over a same-cycle press.
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          // Read with the current idx, so led trails an idx change by one
          // cycle and a same-cycle write shows up one cycle later.
          led_d = mem_q[idx_q];
          if (press_q) begin
            if (idx_q == IDX_LAST) begin
              idx_d  = '0;
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign led        = led_q;
  assign idx        = idx_q;
  assign showing    = (state_q == SHOW);
  assign wrap_pulse = wrap_q;

endmodule
